alu_exec_unit: RTL and testbench

Execution unit that consumes the 4-bit ALU control code from the ALU decoder and performs the operation on two operands.
- Logic, add/sub, shift and compare ops complete in one cycle.
- Multiply and divide run iteratively over WIDTH cycles.
- A start/busy/done handshake lets the multi-cycle CPU controller stall on long ops.
- Sits in the execute stage, between the decoder/register file and writeback.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_iter_muldiv.sv | 59 +++++
 rtl/alu_exec_unit.sv | 109 ++++++++++
 tb/tb_alu_exec_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes shared with the decoder, exec-unit FSM states and a width helper.
package alu_pkg;
    localparam logic [3:0] ALU_ADD     = 4'b0001;
    localparam logic [3:0] ALU_ADD_ALT = 4'b0011;
    localparam logic [3:0] ALU_SUB     = 4'b0010;
    localparam logic [3:0] ALU_SUB_ALT = 4'b0100;
    localparam logic [3:0] ALU_MUL     = 4'b0101;
    localparam logic [3:0] ALU_DIV     = 4'b0110;
    localparam logic [3:0] ALU_OR      = 4'b0111;
    localparam logic [3:0] ALU_AND     = 4'b1000;
    localparam logic [3:0] ALU_XOR     = 4'b1001;
    localparam logic [3:0] ALU_SLL     = 4'b1010;
    localparam logic [3:0] ALU_SRL     = 4'b1011;
    localparam logic [3:0] ALU_SLT     = 4'b1100;

    typedef enum logic {IDLE, MULDIV} state_t;

    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: iterative shift-add multiplier / restoring divider, one bit per cycle.
// Outputs are the post-step values, so they are final during the cycle o_finish is high.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_finish
);
    localparam int CNT_W = clog2(WIDTH) + 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_div;
    logic [WIDTH-1:0] r_acc, r_q, r_m;
    logic [WIDTH:0]   w_sh, w_diff;
    logic [WIDTH-1:0] w_acc_n, w_q_n;

    // div: r_acc is the partial remainder, r_q shifts dividend out / quotient in
    // mul: r_acc accumulates, r_q is the multiplier consumed LSB first
    always_comb begin
        w_sh     = {r_acc, r_q[WIDTH-1]};
        w_diff   = w_sh - {1'b0, r_m};
        w_acc_n  = r_div ? (w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0])
                         : (r_q[0] ? r_acc + r_m : r_acc);
        w_q_n    = r_div ? {r_q[WIDTH-2:0], ~w_diff[WIDTH]} : r_q >> 1;
        o_quot   = r_div ? w_q_n : w_acc_n;
        o_rem    = r_div ? w_acc_n : '0;
        o_finish = r_cnt == CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_div <= 1'b0;
            r_acc <= '0;
            r_q   <= '0;
            r_m   <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(WIDTH);
            r_div <= i_div;
            r_acc <= '0;
            r_q   <= i_a;
            r_m   <= i_b;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            r_acc <= w_acc_n;
            r_q   <= w_q_n;
            r_m   <= r_div ? r_m : r_m << 1;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with single-cycle ops and an iterative mul/div
// behind a start/busy/done handshake.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [CTRL_W-1:0] i_alu_control,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    output logic [WIDTH-1:0]  o_result,
    output logic [WIDTH-1:0]  o_remainder,
    output logic              o_zero,
    output logic              o_error,
    output logic              o_busy,
    output logic              o_done
);
    localparam int SH_W = clog2(WIDTH);

    state_t           r_state, w_state_n;
    logic [WIDTH-1:0] r_result, r_rem, w_res, w_rem, w_md_q, w_md_r;
    logic             r_zero, r_err, r_done, w_err, w_md, w_accept, w_load, w_fin;
    logic [SH_W-1:0]  w_sh;

    always_comb begin
        w_sh  = i_b[SH_W-1:0];
        w_res = '0;
        w_rem = '0;
        w_err = 1'b0;
        case (i_alu_control)
            ALU_ADD, ALU_ADD_ALT: w_res = i_a + i_b;
            ALU_SUB, ALU_SUB_ALT: w_res = i_a - i_b;
            ALU_MUL:              w_res = '0;
            ALU_DIV: begin
                w_res = i_b == '0 ? '1 : '0;
                w_rem = i_b == '0 ? i_a : '0;
                w_err = i_b == '0;
            end
            ALU_OR:               w_res = i_a | i_b;
            ALU_AND:              w_res = i_a & i_b;
            ALU_XOR:              w_res = i_a ^ i_b;
            ALU_SLL:              w_res = i_a << w_sh;
            ALU_SRL:              w_res = i_a >> w_sh;
            ALU_SLT:              w_res = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            default:              w_err = 1'b1;
        endcase
    end

    // divide-by-zero short-circuits to the single-cycle path
    always_comb begin
        w_md      = i_alu_control == ALU_MUL || (i_alu_control == ALU_DIV && i_b != '0);
        w_accept  = i_start && r_state == IDLE;
        w_load    = w_accept && w_md;
        w_state_n = r_state == IDLE ? (w_load ? MULDIV : IDLE) : (w_fin ? IDLE : MULDIV);
    end

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_div    (i_alu_control == ALU_DIV),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_quot   (w_md_q),
        .o_rem    (w_md_r),
        .o_finish (w_fin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_rem    <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept && !w_md) begin
                r_result <= w_res;
                r_rem    <= w_rem;
                r_zero   <= w_res == '0;
                r_err    <= w_err;
                r_done   <= 1'b1;
            end else if (r_state == MULDIV && w_fin) begin
                r_result <= w_md_q;
                r_rem    <= w_md_r;
                r_zero   <= w_md_q == '0;
                r_err    <= 1'b0;
                r_done   <= 1'b1;
            end
        end
    end

    assign o_result    = r_result;
    assign o_remainder = r_rem;
    assign o_zero      = r_zero;
    assign o_error     = r_err;
    assign o_busy      = r_state == MULDIV;
    assign o_done      = r_done;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and random checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [3:0]  ctrl = '0;
    logic [31:0] opa = '0, opb = '0, result, remainder;
    logic        zero, error, busy, done;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_alu_control(ctrl), .i_a(opa), .i_b(opb),
        .o_result(result), .o_remainder(remainder), .o_zero(zero), .o_error(error),
        .o_busy(busy), .o_done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [31:0] rem, output logic err,
                         output int lat);
        logic [63:0] p;
        res = 0; rem = 0; err = 0; lat = 1;
        case (c)
            4'd1, 4'd3: res = a + b;
            4'd2, 4'd4: res = a - b;
            4'd5: begin p = {32'd0, a} * {32'd0, b}; res = p[31:0]; lat = 33; end
            4'd6: if (b == 0) begin res = 32'hFFFF_FFFF; rem = a; err = 1; end
                  else begin res = a / b; rem = a % b; lat = 33; end
            4'd7:  res = a | b;
            4'd8:  res = a & b;
            4'd9:  res = a ^ b;
            4'd10: res = a << (b % 32);
            4'd11: res = a >> (b % 32);
            4'd12: res = ($signed(a) < $signed(b)) ? 1 : 0;
            default: err = 1;
        endcase
    endtask

    // call at a negedge; returns at the negedge of the first cycle after accept
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        start = 1; ctrl = c; opa = a; opb = b;
        @(negedge clk);
        start = 0;
    endtask

    // waits for done (bounded), optionally pokes a start mid-op, then checks everything
    task automatic await_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                            input logic [31:0] b, input bit poke);
        logic [31:0] er, em;
        logic        ee;
        int          el, lat, bc;
        model(c, a, b, er, em, ee, el);
        lat = 1; bc = 0;
        while (!done && lat < 100) begin
            if (busy) bc++;
            start = poke && lat == 5;
            if (start) begin ctrl = ALU_ADD; opa = $urandom; opb = $urandom; end
            @(negedge clk);
            lat++;
        end
        start = 0;
        chk({tag, "_latency"}, lat, el);
        chk({tag, "_busy_cycles"}, bc, el == 33 ? 32 : 0);
        chk({tag, "_result"}, result, er);
        chk({tag, "_remainder"}, remainder, em);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, er == 0});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, ee});
    endtask

    initial begin
        logic [3:0]  c;
        logic [31:0] a, b;
        int          nd;
        repeat (3) @(negedge clk);
        chk("reset_result", result, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_flags", {28'd0, zero, error, busy, done}, 0);
        rst = 0;
        @(negedge clk);

        issue(4'b0001, 5, 7);               await_op("add", 4'b0001, 5, 7, 0);
        issue(4'b0100, 7, 7);               await_op("sub_zero", 4'b0100, 7, 7, 0);
        issue(ALU_MUL, 32'hFFFF_FFFF, 2);   await_op("mul_poke", ALU_MUL, 32'hFFFF_FFFF, 2, 1);
        @(negedge clk);
        chk("no_extra_done", {31'd0, done}, 0);
        chk("result_holds", result, 32'hFFFF_FFFE);
        issue(ALU_DIV, 100, 7);             await_op("div", ALU_DIV, 100, 7, 0);
        issue(ALU_DIV, 9, 0);               await_op("div0", ALU_DIV, 9, 0, 0);
        issue(ALU_SLL, 1, 33);              await_op("sll", ALU_SLL, 1, 33, 0);
        issue(ALU_SRL, 32'h8000_0000, 31);  await_op("srl", ALU_SRL, 32'h8000_0000, 31, 0);
        issue(ALU_SLT, 32'hFFFF_FFFF, 1);   await_op("slt", ALU_SLT, 32'hFFFF_FFFF, 1, 0);
        issue(4'b0000, 3, 4);               await_op("illegal", 4'b0000, 3, 4, 0);
        issue(ALU_XOR, 32'hA5A5_0F0F, 32'h0F0F_0F0F);
        await_op("xor", ALU_XOR, 32'hA5A5_0F0F, 32'h0F0F_0F0F, 0);

        // reset in the middle of a multiply
        issue(ALU_MUL, 1234, 5678);
        repeat (9) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_result", result, 0);
        @(negedge clk);
        rst = 0;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("rst_no_done", nd, 0);
        issue(ALU_ADD, 40, 2);              await_op("post_rst_add", ALU_ADD, 40, 2, 0);

        // back-to-back: add issued in the multiply's done cycle
        issue(ALU_MUL, 300, 7);             await_op("b2b_mul", ALU_MUL, 300, 7, 0);
        issue(ALU_ADD_ALT, 11, 22);         await_op("b2b_add", ALU_ADD_ALT, 11, 22, 0);

        for (int i = 0; i < 40; i++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
            issue(c, a, b);
            await_op("rand", c, a, b, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
